fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit that drives the instruction memory's read/write port (address, write strobe, write data) and consumes its registered one-cycle-latency read data. It streams sequential instructions with their PCs to decode through a valid/ready handshake, supports branch redirect with flush, and multiplexes a program-load write path onto the same memory port. It sits between instruction memory and the decode stage of the venus core.

## Interface
- RESET_PC, 0, PC loaded on reset (ADDR bits)
- ADDR, WORD: the core-wide values from the shared params include (not overridden locally)
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- run  in  1  1 = fetch may issue reads; 0 = issue paused (in-flight read still completes)
- mem_a  out  ADDR  instruction memory address
- mem_w  out  1  instruction memory write strobe
- mem_d  out  WORD  instruction memory write data
- mem_q  in  WORD  instruction memory read data, valid the cycle after its address
- if_valid  out  1  instruction available to decode
- if_instr  out  WORD  instruction word
- if_pc  out  ADDR  address of if_instr
- id_ready  in  1  decode accepts; transfer when if_valid & id_ready
- redir_valid  in  1  branch redirect strobe
- redir_pc  in  ADDR  redirect target
- ld_valid  in  1  program-load write request (always accepted, one word per cycle)
- ld_addr  in  ADDR  load address
- ld_data  in  WORD  load data

## Operation
- State: pc (next address to fetch), inflight bit + inflight_pc, 2-entry output FIFO of {pc, instr}.
- Port mux priority per cycle: ld_valid > fetch issue. ld_valid: mem_w=1, mem_a=ld_addr, mem_d=ld_data, no issue. Otherwise mem_w=0, mem_d=0, mem_a = (redir_valid ? redir_pc : pc).
- pop = if_valid & id_ready. Issue condition: run & ~ld_valid & (count − pop + inflight ≤ 1), or redir_valid & run & ~ld_valid (redirect ignores occupancy since FIFO is flushed).
- Issue: inflight<=1, inflight_pc<=mem_a, pc<=mem_a+1 (mod 2^ADDR; LEN not checked, out-of-range reads are software's problem).
- Cycle after issue: mem_q with inflight_pc pushed into FIFO unless killed.
- Redirect: FIFO cleared, current inflight killed (mem_q ignored next cycle), pc<=redir_pc (or redir_pc+1 if issued same cycle). Pop in the redirect cycle is still a valid transfer to decode.
- redir_valid & ld_valid same cycle: load wins port; flush still happens; pc<=redir_pc, no issue.
- Load does not flush or change pc; a write to an address already fetched/buffered is not reflected (software must redirect afterwards).
- No-issue cycle: inflight<=0 (after its data is consumed).

## Timing
- Reset (rst=0 at posedge): pc=RESET_PC, FIFO empty, inflight=0; if_valid=0, if_instr=0, if_pc=0, mem_w=0, mem_d=0, mem_a=RESET_PC.
- Latency: address on mem_a in cycle t -> mem_q in t+1 -> if_valid in t+2 (if_* registered from FIFO head).
- Sustained throughput 1 instr/cycle with id_ready held high.
- id_ready low: FIFO fills to 2, issue stops; no instruction dropped or duplicated; resume on next pop.
- Redirect in cycle t: if_valid=0 in t+1; target instruction valid in t+2.
- rst asserted mid-operation discards FIFO and inflight unconditionally.

## Structure
- ADDR, WORD come from the shared params include; no new package types.
- One sub-module fetch_buffer: 2-entry FIFO {ADDR+WORD} with push, pop, flush, count; flush beats push in same cycle.
- fetch_unit holds pc, inflight tracking, issue logic and port mux.

## Test plan
- Reset with RESET_PC=0x10, run=1, id_ready=1 -> mem_a=0x10,0x11,0x12…; if_valid first high 2 cycles after rst release with if_pc=0x10, then consecutive PCs each cycle.
- id_ready low 5 cycles mid-stream -> at most 2 buffered, issue stalls, PCs resume contiguous with no gap or repeat.
- redir_valid with redir_pc=0x40 while FIFO full and inflight -> if_valid=0 next cycle, next delivered if_pc=0x40, then 0x41.
- ld_valid writes 0xDEADBEEF to 0x08 with run=0, then redirect to 0x08 -> mem_w=1 during load only, delivered if_instr=0xDEADBEEF, if_pc=0x08.
- Simultaneous redir_valid(0x20) and ld_valid -> mem_w=1, FIFO flushed, next cycle mem_a=0x20 issued.
- pc at 2^ADDR−1 -> next fetch address wraps to 0; rst low mid-stream -> if_valid=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Core-wide address and instruction word widths shared by the fetch path.
package fetch_unit_pkg;
    localparam int ADDR = 8;
    localparam int WORD = 32;
endpackage

// File: rtl/fetch_unit_fetch_buffer.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
// Entry 0 is always the head; a flush wins over a push in the same cycle.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic [ADDR-1:0] i_push_pc,
    input  logic [WORD-1:0] i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [1:0]      o_count,
    output logic [ADDR-1:0] o_head_pc,
    output logic [WORD-1:0] o_head_instr
);
    logic [ADDR-1:0] r_pc    [2];
    logic [WORD-1:0] r_instr [2];
    logic [1:0]      r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    r_pc[r_count[0]]    <= i_push_pc;
                    r_instr[r_count[0]] <= i_push_instr;
                    r_count             <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc[0]    <= r_pc[1];
                    r_instr[0] <= r_instr[1];
                    r_count    <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_pc[0]    <= i_push_pc;
                        r_instr[0] <= i_push_instr;
                    end else begin
                        r_pc[0]    <= r_pc[1];
                        r_instr[0] <= r_instr[1];
                        r_pc[1]    <= i_push_pc;
                        r_instr[1] <= i_push_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_pc    = r_pc[0];
    assign o_head_instr = r_instr[0];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc and in-flight tracking, issue control, memory port mux
// (program load has priority over fetch), and the decode-side output buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q,
    output logic            if_valid,
    output logic [WORD-1:0] if_instr,
    output logic [ADDR-1:0] if_pc,
    input  logic            id_ready,
    input  logic            redir_valid,
    input  logic [ADDR-1:0] redir_pc,
    input  logic            ld_valid,
    input  logic [ADDR-1:0] ld_addr,
    input  logic [WORD-1:0] ld_data
);
    logic [ADDR-1:0] r_pc;
    logic [ADDR-1:0] r_inflight_pc;
    logic            r_inflight;

    logic [1:0]      w_count;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_room;
    logic            w_issue;

    assign if_valid = (w_count != 2'd0);
    assign w_pop    = if_valid & id_ready;

    assign mem_w = ld_valid;
    assign mem_d = ld_valid ? ld_data : '0;
    assign mem_a = ld_valid ? ld_addr : (redir_valid ? redir_pc : r_pc);

    // Buffered plus in-flight words left after this cycle's pop must leave a free slot.
    assign w_occ   = 3'(w_count) + 3'(r_inflight);
    assign w_room  = (w_occ <= (3'd1 + 3'(w_pop)));
    assign w_issue = run & ~ld_valid & (redir_valid | w_room);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= mem_a;
                r_pc          <= mem_a + ADDR'(1);
            end else if (redir_valid) begin
                r_pc <= redir_pc;
            end
        end
    end

    // Read data returning during a redirect is dropped by the flush.
    fetch_buffer u_buf (
        .clk          (clk),
        .i_rst_n      (rst),
        .i_push       (r_inflight),
        .i_push_pc    (r_inflight_pc),
        .i_push_instr (mem_q),
        .i_pop        (w_pop),
        .i_flush      (redir_valid),
        .o_count      (w_count),
        .o_head_pc    (if_pc),
        .o_head_instr (if_instr)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a mux/pc vector table,
// and randomized traffic scored against an expected-PC stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [7:0] RST_PC = 8'h10;

    logic            clk = 1'b0;
    logic            rst, run, id_ready, redir_valid, ld_valid;
    logic [ADDR-1:0] redir_pc, ld_addr, mem_a, if_pc;
    logic [WORD-1:0] ld_data, mem_d, mem_q, if_instr;
    logic            mem_w, if_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Instruction memory: registered read, one-cycle latency.
    logic [WORD-1:0] mem [256];
    logic            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= $urandom;
            mem_ready <= 1'b1;
        end else begin
            if (mem_w) mem[mem_a] <= mem_d;
            mem_q <= mem[mem_a];
        end
    end

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    logic [7:0] exp_pc = RST_PC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: decode must see contiguous PCs from the last reset/redirect target.
    always @(negedge clk) begin
        if (mem_ready) begin
            chk("mem_w", 32'(mem_w), 32'(ld_valid));
            chk("mem_d", mem_d, ld_valid ? ld_data : 32'd0);
            if (ld_valid)         chk("mem_a_ld", 32'(mem_a), 32'(ld_addr));
            else if (redir_valid) chk("mem_a_redir", 32'(mem_a), 32'(redir_pc));
            if (rst && if_valid && id_ready) begin
                chk("xfer_pc", 32'(if_pc), 32'(exp_pc));
                chk("xfer_instr", if_instr, mem[exp_pc]);
                exp_pc = exp_pc + 8'd1;
                n_xfer++;
            end
            if (!rst)             exp_pc = RST_PC;
            else if (redir_valid) exp_pc = redir_pc;
        end
    end

    typedef struct {
        logic        ld;
        logic [7:0]  la;
        logic [31:0] ldd;
        logic        rd;
        logic [7:0]  ra;
        logic        ew;
        logic [7:0]  ea;
        logic [31:0] ed;
        logic [7:0]  enext;
    } vec_t;
    vec_t tbl [7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tmp8;
    int         snap;
    logic       got;

    initial begin
        rst = 1'b0; run = 1'b0; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

        // With run=0 the pc only moves on redirect, so each record's next-cycle
        // fetch address follows from the rules alone.
        tbl[0] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 8'h30, 32'h0,        8'h30};
        tbl[1] = '{1'b1, 8'h90, 32'h11112222, 1'b0, 8'h00, 1'b1, 8'h90, 32'h11112222, 8'h30};
        tbl[2] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'h50, 1'b0, 8'h50, 32'h0,        8'h50};
        tbl[3] = '{1'b1, 8'h91, 32'hA5A5A5A5, 1'b1, 8'h60, 1'b1, 8'h91, 32'hA5A5A5A5, 8'h60};
        tbl[4] = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 8'h60, 32'h0,        8'h60};
        tbl[5] = '{1'b0, 8'h00, 32'h0,        1'b1, 8'hFF, 1'b0, 8'hFF, 32'h0,        8'hFF};
        tbl[6] = '{1'b1, 8'h92, 32'h33334444, 1'b0, 8'h00, 1'b1, 8'h92, 32'h33334444, 8'hFF};

        repeat (3) cyc();
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        chk("rst_mem_w", 32'(mem_w), 32'd0);
        chk("rst_mem_d", mem_d, 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'(RST_PC));

        // Start-up stream and latency
        rst = 1'b1; run = 1'b1; id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            #1;
            chk("start_mem_a", 32'(mem_a), 32'(RST_PC) + 32'(k));
            chk("start_valid", 32'(if_valid), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) chk("start_pc", 32'(if_pc), 32'(RST_PC) + 32'(k - 2));
        end

        // Backpressure: buffer fills, issue stalls, stream resumes intact
        cyc(); id_ready = 1'b0;
        repeat (4) cyc();
        #1;
        tmp8 = exp_pc + 8'd2;
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_head", 32'(if_pc), 32'(exp_pc));
        chk("stall_mem_a", 32'(mem_a), 32'(tmp8));
        cyc(); id_ready = 1'b1; snap = n_xfer;
        repeat (4) cyc();
        #1;
        chk("resume_rate", 32'(n_xfer - snap), 32'd4);

        // Redirect while the buffer is full
        cyc(); id_ready = 1'b0;
        repeat (3) cyc();
        redir_valid = 1'b1; redir_pc = 8'h40;
        cyc(); redir_valid = 1'b0; id_ready = 1'b1;
        #1;
        chk("redir_flush", 32'(if_valid), 32'd0);
        cyc(); #1;
        chk("redir_valid", 32'(if_valid), 32'd1);
        chk("redir_pc0", 32'(if_pc), 32'h40);
        cyc(); #1;
        chk("redir_pc1", 32'(if_pc), 32'h41);

        // Program load, then redirect onto the loaded word
        cyc(); run = 1'b0;
        repeat (4) cyc();
        ld_valid = 1'b1; ld_addr = 8'h08; ld_data = 32'hDEADBEEF;
        #1;
        chk("ld_mem_w", 32'(mem_w), 32'd1);
        chk("ld_mem_d", mem_d, 32'hDEADBEEF);
        cyc(); ld_valid = 1'b0;
        #1;
        chk("ld_mem_w_off", 32'(mem_w), 32'd0);
        cyc(); run = 1'b1; redir_valid = 1'b1; redir_pc = 8'h08;
        cyc(); redir_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (if_valid) begin got = 1'b1; break; end
            cyc();
        end
        chk("ld_fetch_seen", 32'(got), 32'd1);
        chk("ld_fetch_pc", 32'(if_pc), 32'h08);
        chk("ld_fetch_instr", if_instr, 32'hDEADBEEF);

        // Port mux / pc update table, issue paused
        cyc(); run = 1'b0;
        cyc(); redir_valid = 1'b1; redir_pc = 8'h30;
        cyc(); redir_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = tbl[i].ld; ld_addr = tbl[i].la; ld_data = tbl[i].ldd;
            redir_valid = tbl[i].rd; redir_pc = tbl[i].ra;
            #1;
            chk("tbl_mem_w", 32'(mem_w), 32'(tbl[i].ew));
            chk("tbl_mem_a", 32'(mem_a), 32'(tbl[i].ea));
            chk("tbl_mem_d", mem_d, tbl[i].ed);
            cyc();
            ld_valid = 1'b0; redir_valid = 1'b0;
            #1;
            chk("tbl_next_a", 32'(mem_a), 32'(tbl[i].enext));
        end

        // Address wrap from 0xFF
        run = 1'b1; id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            #1;
            if (k == 0) chk("wrap_a0", 32'(mem_a), 32'hFF);
            if (k == 1) chk("wrap_a1", 32'(mem_a), 32'h00);
            if (k == 1) chk("wrap_v1", 32'(if_valid), 32'd0);
            if (k == 2) chk("wrap_pc0", 32'(if_pc), 32'hFF);
            if (k == 3) chk("wrap_pc1", 32'(if_pc), 32'h00);
        end

        // Simultaneous load and redirect
        repeat (3) cyc();
        redir_valid = 1'b1; redir_pc = 8'h20;
        ld_valid = 1'b1; ld_addr = 8'hC0; ld_data = $urandom;
        #1;
        chk("both_mem_w", 32'(mem_w), 32'd1);
        chk("both_mem_a", 32'(mem_a), 32'hC0);
        cyc(); redir_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("both_flush", 32'(if_valid), 32'd0);
        chk("both_issue", 32'(mem_a), 32'h20);
        cyc(); cyc(); #1;
        chk("both_valid", 32'(if_valid), 32'd1);
        chk("both_pc", 32'(if_pc), 32'h20);

        // Reset mid-stream
        repeat (3) cyc();
        rst = 1'b0;
        cyc(); rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(if_valid), 32'd0);
        chk("mrst_mem_a", 32'(mem_a), 32'(RST_PC));
        cyc(); cyc(); #1;
        chk("mrst_restart_v", 32'(if_valid), 32'd1);
        chk("mrst_restart_pc", 32'(if_pc), 32'(RST_PC));

        // Random traffic; loads stay clear of anything buffered or in flight
        for (int c = 0; c < 1500; c++) begin
            cyc();
            id_ready    = ($urandom_range(0, 3) != 0);
            run         = ($urandom_range(0, 9) != 0);
            redir_valid = ($urandom_range(0, 19) == 0);
            redir_pc    = 8'($urandom_range(0, 127));
            ld_valid    = (exp_pc < 8'hB0) && ($urandom_range(0, 19) == 0);
            ld_addr     = 8'hC0 + 8'($urandom_range(0, 15));
            ld_data     = $urandom;
        end
        cyc();
        run = 1'b1; id_ready = 1'b1; redir_valid = 1'b0; ld_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (if_valid) begin got = 1'b1; break; end
            cyc();
        end
        chk("final_live", 32'(got), 32'd1);
        snap = n_xfer;
        repeat (6) cyc();
        #1;
        chk("final_rate", 32'(n_xfer - snap), 32'd6);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
